dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped write-back data cache between the memory stage and a
//  handshaked backing memory. Serves memRead/memWrite from the EX/MEM
//  register; on a miss asserts stall to freeze the pipeline, evicts a dirty
//  victim, refills the line, then completes the access.
// PARAMETERS
//  LINES    32   number of cache lines, power of 2; IDX_W = log2(LINES)
//  TIMEOUT  64   max cycles waiting for mem_ack before err (>=2)
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, asynchronous, active-low
//  addr       in   16  byte address (ALU result)
//  writeData  in   16  store data
//  memRead    in   1   load request
//  memWrite   in   1   store request
//  readData   out  16  load data, valid when done & memRead, else 0
//  stall      out  1   pipeline hold during miss service
//  done       out  1   1-cycle pulse: access completed
//  cacheHit   out  1   1 when done on first-cycle hit
//  err        out  1   1-cycle pulse: illegal access or memory timeout
//  mem_addr   out  16  backing memory word address (byte, aligned)
//  mem_rd     out  1   backing read request, held until mem_ack
//  mem_wr     out  1   backing write request, held until mem_ack
//  mem_wdata  out  16  backing write data
//  mem_rdata  in   16  backing read data, valid with mem_ack
//  mem_ack    in   1   backing handshake complete (one word)
// BEHAVIOUR
//  - Line = 4 words. addr[0] byte (must be 0), addr[2:1] word,
//    addr[3+IDX_W-1:3] index, remaining upper bits tag.
//  - Reset (async, rst=0): all valid/dirty bits 0, FSM IDLE, word counter
//    and timeout counter 0, every output 0; mem_rd/mem_wr drop immediately.
//  - IDLE: request = memRead|memWrite. Hit (valid & tag match): same cycle
//    done=1, cacheHit=1, stall=0; load drives readData; store writes word,
//    sets dirty at clock edge. Miss: stall=1 combinationally; next state
//    EVICT if victim valid&dirty, else FILL.
//  - EVICT: 4 writes, words 0..3 of victim at {victimTag,index,cnt,0};
//    each mem_wr held until mem_ack; after 4th ack -> FILL, cnt=0.
//  - FILL: 4 reads at {reqTag,index,cnt,0}; data written on each ack;
//    after 4th ack tag<=reqTag, valid=1, dirty=0 -> RETRY.
//  - RETRY: perform access as hit, done=1, cacheHit=0, stall=0 -> IDLE.
//  - Miss latency: 1 + per-word ack cycles (4 or 8 words) + 1 RETRY cycle.
//  - stall=1 in EVICT and FILL and the IDLE miss cycle; 0 in RETRY.
//  - Pipeline holds addr/writeData/memRead/memWrite stable while stall=1;
//    input changes during stall are ignored (request latched at miss).
//  - Illegal in IDLE: addr[0]=1 with a request, or memRead&memWrite:
//    err=1, done=0, stall=0, no state/array change.
//  - Timeout: counter resets on each ack; reaching TIMEOUT in EVICT/FILL ->
//    err=1, line valid=0, mem_rd/mem_wr drop, -> IDLE, no done.
//  - mem_ack with no outstanding request: ignored.
//  - Index wrap: index field uses IDX_W bits only; tag is 16-3-IDX_W bits.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds outputs hitCount[15:0], missCount[15:0],
//   saturating at 16'hFFFF, +1 per IDLE hit / per miss entry, reset 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, EVICT, FILL, RETRY),
//  LINE_WORDS=4, address field width constants.
//  Sub-module dcache_array: tag/valid/dirty/data storage, 1 read port
//  (comb), 1 word-write port, tag-write with valid/dirty set/clear.
// TESTING
//  - Read 0x0040 cold, backing ack 1 cycle -> FILL 4 reads 0x0040..0x0046,
//    RETRY done=1 cacheHit=0 readData=mem[0x0040].
//  - Read 0x0042 after above -> same-cycle done=1 cacheHit=1, no mem_rd.
//  - Write 0x0040=0xBEEF, then read 0x0040+LINES*8 -> EVICT writes 0xBEEF
//    to 0x0040 first, then FILL new line, done on RETRY.
//  - memRead with addr=0x0011 -> err pulse 1 cycle, stall=0, no mem access.
//  - Miss with mem_ack never asserted -> err after TIMEOUT=64 cycles,
//    stall drops, subsequent read of same addr misses again.
//  - rst low mid-FILL (word 2) -> outputs 0 immediately; after release,
//    prior hit address misses (valid cleared).

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
package dcache_ctrl_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WORD_W     = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W      = WORD_W + 1;

  typedef enum logic [1:0] {StIdle, StEvict, StFill, StRetry} state_e;

endpackage

// File: rtl/dcache_ctrl_if.sv
// Handshaked backing-memory bus; master side is the cache controller.
interface dcache_ctrl_if;
  import dcache_ctrl_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read of one line, one word-write
// port and a line-metadata write port.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned IdxW = 5,
  parameter int unsigned TagW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IdxW-1:0]   idx,
  input  logic [WORD_W-1:0] rdWord,
  output logic [TagW-1:0]   rdTag,
  output logic              rdValid,
  output logic              rdDirty,
  output logic [DATA_W-1:0] rdData,
  input  logic              wordWe,
  input  logic              wordDirty,
  input  logic [WORD_W-1:0] wrWord,
  input  logic [DATA_W-1:0] wrData,
  input  logic              lineWe,
  input  logic [TagW-1:0]   lineTag,
  input  logic              lineValid
);

  localparam int unsigned Lines = 1 << IdxW;

  logic [TagW-1:0]   tagMem  [Lines];
  logic [DATA_W-1:0] dataMem [Lines*LINE_WORDS];
  logic [Lines-1:0]  validQ;
  logic [Lines-1:0]  dirtyQ;

  assign rdTag   = tagMem[idx];
  assign rdValid = validQ[idx];
  assign rdDirty = dirtyQ[idx];
  assign rdData  = dataMem[{idx, rdWord}];

  // A line write always leaves the line clean (refill done or line dropped).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validQ <= '0;
      dirtyQ <= '0;
    end else if (lineWe) begin
      validQ[idx] <= lineValid;
      dirtyQ[idx] <= 1'b0;
    end else if (wordWe && wordDirty) begin
      dirtyQ[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wordWe) dataMem[{idx, wrWord}] <= wrData;
    if (lineWe) tagMem[idx] <= lineTag;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller. Define DCACHE_STATS_EN to add
// saturating hitCount/missCount outputs.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned LINES   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              memRead,
  input  logic              memWrite,
  output logic [DATA_W-1:0] readData,
  output logic              stall,
  output logic              done,
  output logic              cacheHit,
  output logic              err,
  dcache_ctrl_if.master     mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       hitCount,
  output logic [15:0]       missCount
`endif
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = ADDR_W - OFF_W - IdxW;
  localparam int unsigned TmoW = $clog2(TIMEOUT);

  state_e            stateQ, stateD;
  logic [WORD_W-1:0] cntQ, cntD;
  logic [TmoW-1:0]   tmoQ, tmoD;
  logic [ADDR_W-1:0] reqAddrQ;
  logic [DATA_W-1:0] reqDataQ;
  logic              reqReadQ, reqWriteQ, latchReq;

  logic [ADDR_W-1:0] curAddr;
  logic [DATA_W-1:0] curData;
  logic              curRead, curWrite, hit;
  logic [IdxW-1:0]   idx;
  logic [TagW-1:0]   curTag, rdTag;
  logic [WORD_W-1:0] curWord, rdWord, wrWord;
  logic              rdValid, rdDirty, wordWe, wordDirty, lineWe, lineValid;
  logic [DATA_W-1:0] rdData, wrData;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              memRd, memWr;

  // Outside IDLE the request latched at the miss is authoritative.
  assign curAddr  = (stateQ == StIdle) ? addr      : reqAddrQ;
  assign curData  = (stateQ == StIdle) ? writeData : reqDataQ;
  assign curRead  = (stateQ == StIdle) ? memRead   : reqReadQ;
  assign curWrite = (stateQ == StIdle) ? memWrite  : reqWriteQ;
  assign idx      = curAddr[OFF_W +: IdxW];
  assign curTag   = curAddr[ADDR_W-1 -: TagW];
  assign curWord  = curAddr[1 +: WORD_W];
  assign rdWord   = (stateQ == StEvict) ? cntQ : curWord;
  assign hit      = rdValid && (rdTag == curTag);

  dcache_array #(
    .IdxW (IdxW),
    .TagW (TagW)
  ) uArray (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .rdWord    (rdWord),
    .rdTag     (rdTag),
    .rdValid   (rdValid),
    .rdDirty   (rdDirty),
    .rdData    (rdData),
    .wordWe    (wordWe),
    .wordDirty (wordDirty),
    .wrWord    (wrWord),
    .wrData    (wrData),
    .lineWe    (lineWe),
    .lineTag   (curTag),
    .lineValid (lineValid)
  );

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    tmoD      = tmoQ;
    latchReq  = 1'b0;
    readData  = '0;
    stall     = 1'b0;
    done      = 1'b0;
    cacheHit  = 1'b0;
    err       = 1'b0;
    memAddr   = '0;
    memWdata  = '0;
    memRd     = 1'b0;
    memWr     = 1'b0;
    wordWe    = 1'b0;
    wordDirty = 1'b0;
    wrWord    = curWord;
    wrData    = curData;
    lineWe    = 1'b0;
    lineValid = 1'b0;
    // Outputs are forced low while reset is asserted.
    if (rst) begin
      case (stateQ)
        StIdle: begin
          if (curRead || curWrite) begin
            if (curAddr[0] || (curRead && curWrite)) begin
              err = 1'b1;
            end else if (hit) begin
              done     = 1'b1;
              cacheHit = 1'b1;
              if (curRead) begin
                readData = rdData;
              end else begin
                wordWe    = 1'b1;
                wordDirty = 1'b1;
              end
            end else begin
              stall    = 1'b1;
              latchReq = 1'b1;
              cntD     = '0;
              tmoD     = '0;
              stateD   = (rdValid && rdDirty) ? StEvict : StFill;
            end
          end
        end
        StEvict, StFill: begin
          stall = 1'b1;
          if (stateQ == StEvict) begin
            memWr    = 1'b1;
            memAddr  = {rdTag, idx, cntQ, 1'b0};
            memWdata = rdData;
          end else begin
            memRd   = 1'b1;
            memAddr = {curTag, idx, cntQ, 1'b0};
          end
          if (mem.mem_ack) begin
            tmoD = '0;
            cntD = cntQ + 2'd1;
            if (stateQ == StFill) begin
              wordWe = 1'b1;
              wrWord = cntQ;
              wrData = mem.mem_rdata;
            end
            if (cntQ == 2'd3) begin
              if (stateQ == StEvict) begin
                stateD = StFill;
              end else begin
                lineWe    = 1'b1;
                lineValid = 1'b1;
                stateD    = StRetry;
              end
            end
          end else if (tmoQ == TmoW'(TIMEOUT - 1)) begin
            err    = 1'b1;
            lineWe = 1'b1;
            stateD = StIdle;
          end else begin
            tmoD = tmoQ + 1'b1;
          end
        end
        StRetry: begin
          done = 1'b1;
          if (curRead) begin
            readData = rdData;
          end else begin
            wordWe    = 1'b1;
            wordDirty = 1'b1;
          end
          stateD = StIdle;
        end
        default: stateD = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ    <= StIdle;
      cntQ      <= '0;
      tmoQ      <= '0;
      reqAddrQ  <= '0;
      reqDataQ  <= '0;
      reqReadQ  <= 1'b0;
      reqWriteQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      tmoQ   <= tmoD;
      if (latchReq) begin
        reqAddrQ  <= addr;
        reqDataQ  <= writeData;
        reqReadQ  <= memRead;
        reqWriteQ <= memWrite;
      end
    end
  end

  assign mem.mem_addr  = memAddr;
  assign mem.mem_rd    = memRd;
  assign mem.mem_wr    = memWr;
  assign mem.mem_wdata = memWdata;

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (cacheHit && (hitCount != 16'hFFFF)) hitCount <= hitCount + 16'd1;
      if (latchReq && (missCount != 16'hFFFF)) missCount <= missCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a one-cycle-ack backing memory model.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] writeData = '0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [15:0] readData;
  logic        stall, done, cacheHit, err;
  logic        ackEn = 1'b1;

  dcache_ctrl_if memIf ();

  dcache_ctrl #(
    .LINES   (32),
    .TIMEOUT (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .writeData (writeData),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .readData  (readData),
    .stall     (stall),
    .done      (done),
    .cacheHit  (cacheHit),
    .err       (err),
    .mem       (memIf)
  );

  always #5 clk = ~clk;

  // Backing memory content is a fixed function of the byte address.
  function automatic logic [15:0] memVal(input logic [15:0] a);
    return a ^ 16'hA500;
  endfunction

  initial begin
    memIf.mem_ack   = 1'b0;
    memIf.mem_rdata = '0;
  end

  always @(negedge clk) begin
    memIf.mem_ack   = ackEn && (memIf.mem_rd || memIf.mem_wr);
    memIf.mem_rdata = memVal(memIf.mem_addr);
  end

  int          rdCnt = 0;
  int          wrCnt = 0;
  logic [15:0] rdLogA [64];
  logic [15:0] wrLogA [64];
  logic [15:0] wrLogD [64];

  always @(posedge clk) begin
    if (memIf.mem_ack && memIf.mem_rd && rdCnt < 64) begin
      rdLogA[rdCnt] <= memIf.mem_addr;
      rdCnt         <= rdCnt + 1;
    end
    if (memIf.mem_ack && memIf.mem_wr && wrCnt < 64) begin
      wrLogA[wrCnt] <= memIf.mem_addr;
      wrLogD[wrCnt] <= memIf.mem_wdata;
      wrCnt         <= wrCnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  int          cyc;
  logic        sDone, sErr, sHit, fStall;
  logic [15:0] rdat;
  int          rb, wb;

  // Issue one access and hold it until done or err (bounded), then release.
  task automatic access(input logic [15:0] a, input logic rd, input logic wr,
                        input logic [15:0] wd);
    @(negedge clk);
    addr = a; memRead = rd; memWrite = wr; writeData = wd;
    #1;
    fStall = stall; cyc = -1; sDone = 1'b0; sErr = 1'b0; sHit = 1'b0; rdat = '0;
    for (int i = 0; i < 200; i++) begin
      if (done || err) begin
        cyc = i + 1; sDone = done; sErr = err; sHit = cacheHit; rdat = readData;
        break;
      end
      @(negedge clk); #1;
    end
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  initial begin
    // Reset held with a request pending: every output must stay low.
    addr = 16'h0040; memRead = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_outs", {9'd0, stall, done, err, cacheHit, memIf.mem_rd, memIf.mem_wr, readData},
          32'd0);
    @(negedge clk);
    memRead = 1'b0; rst = 1'b1;

    // Cold read: 1 miss cycle + 4 fill cycles + RETRY.
    rb = rdCnt; wb = wrCnt;
    access(16'h0040, 1'b1, 1'b0, 16'h0);
    check("cold_stall", {31'd0, fStall}, 32'd1);
    check("cold_cyc", cyc, 32'd6);
    check("cold_done_hit", {30'd0, sDone, sHit}, 32'b10);
    check("cold_data", {16'd0, rdat}, 32'h0000_A540);
    check("cold_nrd", rdCnt - rb, 32'd4);
    for (int i = 0; i < 4; i++)
      check("cold_rdaddr", {16'd0, rdLogA[rb+i]}, 32'h40 + 32'(2*i));
    check("cold_nwr", wrCnt - wb, 32'd0);

    // Hit in the same line: same-cycle completion, no memory traffic.
    rb = rdCnt;
    access(16'h0042, 1'b1, 1'b0, 16'h0);
    check("hit_stall", {31'd0, fStall}, 32'd0);
    check("hit_cyc", cyc, 32'd1);
    check("hit_done_hit", {30'd0, sDone, sHit}, 32'b11);
    check("hit_data", {16'd0, rdat}, 32'h0000_A542);
    check("hit_nrd", rdCnt - rb, 32'd0);

    // Misaligned request: err only, no memory access.
    rb = rdCnt; wb = wrCnt;
    access(16'h0011, 1'b1, 1'b0, 16'h0);
    check("odd_err", {29'd0, sErr, sDone, fStall}, 32'b100);
    check("odd_cyc", cyc, 32'd1);
    // Simultaneous read and write: err, store must not land.
    access(16'h0042, 1'b1, 1'b1, 16'h1234);
    check("rw_err", {30'd0, sErr, sDone}, 32'b10);
    access(16'h0042, 1'b1, 1'b0, 16'h0);
    check("rw_nowrite", {15'd0, sHit, rdat}, 32'h0001_A542);
    check("bad_nomem", (rdCnt - rb) + (wrCnt - wb), 32'd0);

    // Store hit then conflicting read: dirty victim written back first.
    access(16'h0040, 1'b0, 1'b1, 16'hBEEF);
    check("st_hit", {15'd0, sHit, rdat}, 32'h0001_0000);
    check("st_cyc", cyc, 32'd1);
    rb = rdCnt; wb = wrCnt;
    access(16'h0140, 1'b1, 1'b0, 16'h0);
    check("ev_cyc", cyc, 32'd10);
    check("ev_done_hit", {30'd0, sDone, sHit}, 32'b10);
    check("ev_data", {16'd0, rdat}, 32'h0000_A440);
    check("ev_nwr", wrCnt - wb, 32'd4);
    check("ev_wr0", {wrLogA[wb], wrLogD[wb]}, 32'h0040_BEEF);
    check("ev_wr3", {wrLogA[wb+3], wrLogD[wb+3]}, 32'h0046_A546);
    check("ev_rd0", {16'd0, rdLogA[rb]}, 32'h0000_0140);

    // No ack ever: err on the 64th FILL cycle, no done.
    ackEn = 1'b0;
    access(16'h0200, 1'b1, 1'b0, 16'h0);
    check("tmo_cyc", cyc, 32'd65);
    check("tmo_err_done", {30'd0, sErr, sDone}, 32'b10);
    #1;
    check("tmo_idle", {30'd0, stall, memIf.mem_rd}, 32'd0);
    ackEn = 1'b1;
    access(16'h0200, 1'b1, 1'b0, 16'h0);
    check("tmo_remiss", cyc, 32'd6);
    check("tmo_redata", {15'd0, sHit, rdat}, 32'h0000_A700);

    access(16'h0140, 1'b1, 1'b0, 16'h0);
    check("pre_rst_hit", {15'd0, sHit, rdat}, 32'h0001_A440);

    // Reset while the third fill word is outstanding.
    rb = rdCnt;
    @(negedge clk);
    addr = 16'h0400; memRead = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("mf_word2", {15'd0, memIf.mem_rd, memIf.mem_addr}, 32'h0001_0404);
    check("mf_nrd", rdCnt - rb, 32'd2);
    rst = 1'b0;
    #1;
    check("mf_rst_outs", {9'd0, stall, done, err, cacheHit, memIf.mem_rd, memIf.mem_wr,
          readData}, 32'd0);
    @(negedge clk);
    memRead = 1'b0; rst = 1'b1;
    access(16'h0140, 1'b1, 1'b0, 16'h0);
    check("post_rst_miss", cyc, 32'd6);
    check("post_rst_data", {15'd0, sHit, rdat}, 32'h0000_A440);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
